// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Function : Buffered 8N1 UART transmitter. Bytes enter through a valid/ready
//             port into a small FIFO and are serialised LSB-first with a
//             runtime-programmable bit period.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int               c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] c_one   = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers (extra MSB is the wrap bit)
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;

    // Shift engine state
    state_t           r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_tx;

    logic [c_ptr_w:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_tick;
    logic [DIV_W-1:0] w_div_eff;
    logic [7:0]       w_head;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                       (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_push    = tx_valid && !w_full;
    // Bit boundary: the down-counter has reached zero
    assign w_tick    = (r_cnt == '0);
    // Pop when idle, or back-to-back at the end of a stop bit
    assign w_pop     = !w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));
    // A divisor of zero behaves as one cycle per bit
    assign w_div_eff = (clk_div == '0) ? c_one : clk_div;
    assign w_head    = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    assign tx_ready   = !w_full;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign fifo_level = w_level;

    // FIFO data array write; contents need no reset since pointers gate reads
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= tx_data;
        end
    end

    // FIFO pointer update on accepted push / engine pop
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Frame FSM with bit-period down-counter and registered serial output
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_div     <= c_one;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_div   <= w_div_eff;
                        r_cnt   <= w_div_eff - c_one;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_cnt     <= r_div - c_one;
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt <= r_div - c_one;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (w_pop) begin
                            // Next frame starts with no idle gap
                            r_shift <= w_head;
                            r_div   <= w_div_eff;
                            r_cnt   <= w_div_eff - c_one;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Function : Self-checking bench for uart_tx_fifo. A serial-line monitor
//             decodes every frame and compares it against a scoreboard of
//             bytes (and their bit period) recorded at acceptance time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic [15:0] clk_div = 16'd4;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] div;
    } exp_t;

    exp_t exp_q[$];
    int   start_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   frames_done = 0;

    bit   mon_active = 1'b0;
    int   mon_bit = 0;
    int   mon_cnt = 0;
    exp_t mon_cur;

    uart_tx_fifo #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .clk_div    (clk_div),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] eff(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    // Serial-line monitor: decodes frames sample-by-sample at the falling edge
    initial begin
        logic eb;
        forever begin
            @(negedge clock);
            if (!resetb) begin
                mon_active = 1'b0;
                exp_q.delete();
            end else begin
                if (!mon_active && tx === 1'b0) begin
                    check("start_has_expect", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) mon_cur = exp_q.pop_front();
                    else                   mon_cur = '{data: 8'h00, div: 16'd1};
                    mon_active = 1'b1;
                    mon_bit    = 0;
                    mon_cnt    = 0;
                    start_cyc.push_back(cyc);
                end
                if (mon_active) begin
                    if (mon_bit == 0)      eb = 1'b0;
                    else if (mon_bit == 9) eb = 1'b1;
                    else                   eb = mon_cur.data[mon_bit-1];
                    check($sformatf("tx_bit%0d_byte%02h", mon_bit, mon_cur.data),
                          32'(tx), 32'(eb));
                    mon_cnt++;
                    if (mon_cnt >= int'(mon_cur.div)) begin
                        mon_cnt = 0;
                        mon_bit++;
                        if (mon_bit == 10) begin
                            mon_active = 1'b0;
                            frames_done++;
                        end
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int waitc = 0;
        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waitc < 500) begin
            @(negedge clock);
            waitc++;
        end
        check("push_ready_wait", 32'(waitc < 500), 32'd1);
        exp_q.push_back('{data: b, div: eff(clk_div)});
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while ((busy !== 1'b0 || mon_active) && n < 2000);
        check("wait_idle", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        int          n0;
        int          busy_cnt;
        logic        tx0, tx1;
        logic [2:0]  lvl0;
        logic [2:0]  max_lvl;
        int          low_cnt;
        int          f0;
        logic [10:0] w0, w1, wexp;
        logic [7:0]  b3c;

        // Reset state
        #23;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        @(negedge clock);
        resetb = 1'b1;

        // Single byte 0xA5 at 4 cycles per bit: latency and busy duration
        clk_div = 16'd4;
        push_byte(8'hA5);
        busy_cnt = 0;
        tx0 = 1'b0; tx1 = 1'b1; lvl0 = 3'd0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (i == 0) begin tx0 = tx; lvl0 = fifo_level; end
            if (i == 1) tx1 = tx;
            if (busy !== 1'b1) break;
            busy_cnt++;
        end
        check("a5_tx_before_start", 32'(tx0), 32'd1);
        check("a5_level_after_push", 32'(lvl0), 32'd1);
        check("a5_tx_start_edge", 32'(tx1), 32'd0);
        check("a5_busy_cycles", 32'(busy_cnt), 32'd41);
        check("a5_tx_idle", 32'(tx), 32'd1);
        wait_idle();

        // Back-to-back 0x00, 0xFF, 0x55 at 2 cycles per bit
        clk_div = 16'd2;
        n0 = start_cyc.size();
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        max_lvl = fifo_level;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            #1;
            if (fifo_level > max_lvl) max_lvl = fifo_level;
            if (busy === 1'b0 && !mon_active) break;
        end
        check("b2b_level_peak", 32'(max_lvl), 32'd2);
        check("b2b_frames", 32'(start_cyc.size() - n0), 32'd3);
        if (start_cyc.size() >= n0 + 3) begin
            check("b2b_gap1", 32'(start_cyc[n0+1] - start_cyc[n0]), 32'd20);
            check("b2b_gap2", 32'(start_cyc[n0+2] - start_cyc[n0+1]), 32'd20);
        end
        wait_idle();

        // Seven bytes at 3 cycles per bit: backpressure and ordering
        clk_div = 16'd3;
        f0 = frames_done;
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i * 17));
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_ready", 32'(tx_ready), 32'd0);
        push_byte(8'hC3);
        push_byte(8'h3A);
        wait_idle();
        check("seven_frames", 32'(frames_done - f0), 32'd7);
        check("seven_queue_drained", 32'(exp_q.size()), 32'd0);

        // clk_div = 0 and clk_div = 1 give identical one-cycle bits
        b3c = 8'h3C;
        wexp[0] = 1'b1;
        wexp[1] = 1'b0;
        for (int i = 0; i < 8; i++) wexp[2+i] = b3c[i];
        wexp[10] = 1'b1;
        clk_div = 16'd0;
        push_byte(b3c);
        for (int i = 0; i < 11; i++) begin @(negedge clock); w0[i] = tx; end
        wait_idle();
        clk_div = 16'd1;
        push_byte(b3c);
        for (int i = 0; i < 11; i++) begin @(negedge clock); w1[i] = tx; end
        wait_idle();
        check("div0_wave", 32'(w0), 32'(wexp));
        check("div0_vs_div1", 32'(w1), 32'(w0));

        // Divisor change mid-frame applies only to the next frame
        clk_div = 16'd8;
        n0 = start_cyc.size();
        push_byte(8'h81);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            #1;
            if (mon_active && mon_bit >= 2) break;
        end
        check("chg_in_data", 32'(mon_bit >= 2), 32'd1);
        clk_div = 16'd2;
        push_byte(8'h7E);
        wait_idle();
        check("chg_frames", 32'(start_cyc.size() - n0), 32'd2);
        if (start_cyc.size() >= n0 + 2)
            check("chg_first_len", 32'(start_cyc[n0+1] - start_cyc[n0]), 32'd80);

        // Asynchronous reset mid-DATA with two bytes queued
        clk_div = 16'd4;
        push_byte(8'h00);
        push_byte(8'h11);
        push_byte(8'h22);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            #1;
            if (mon_active && mon_bit == 4) break;
        end
        check("rst_pre_tx_low", 32'(tx), 32'd0);
        check("rst_pre_level", 32'(fifo_level), 32'd2);
        #1;
        resetb = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        #2;
        resetb = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) low_cnt++;
        end
        check("post_rst_quiet", 32'(low_cnt), 32'd0);

        // A fresh push after reset is transmitted normally
        f0 = frames_done;
        push_byte(8'h5A);
        wait_idle();
        check("post_rst_frame", 32'(frames_done - f0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
